// File: rtl/weight_feeder.sv
// Weight feeder: takes one N x N tile a row at a time, streams it column-skewed
// into the top edge of the systolic array, then fires the per-row switch staircase.
module weight_feeder #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N*DATA_WIDTH-1:0] wf_weight_out,
    output logic [N-1:0]            wf_accept_w_out,
    output logic [N-1:0]            wf_switch_out,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = $clog2(2 * N);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_SWITCH = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]              state, state_nx;
    logic [CW-1:0]           row_cnt, row_nx;
    logic [CW-1:0]           step_cnt, step_nx;
    logic [N*DATA_WIDTH-1:0] tile    [N];
    logic [N*DATA_WIDTH-1:0] tile_nx [N];
    logic [N*DATA_WIDTH-1:0] weight_nx;
    logic [N-1:0]            accept_nx;
    logic [N-1:0]            switch_nx;
    logic                    xfer;

    assign xfer = in_valid & in_ready;

    always_comb begin
        state_nx = state;
        row_nx   = row_cnt;
        step_nx  = step_cnt;
        case (state)
            S_IDLE, S_LOAD: begin
                if (xfer) begin
                    if (row_cnt == CW'(N - 1)) begin
                        state_nx = S_DRAIN;
                        row_nx   = '0;
                        step_nx  = '0;
                    end else begin
                        state_nx = S_LOAD;
                        row_nx   = row_cnt + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (step_cnt == CW'(2 * N - 2)) begin
                    state_nx = S_SWITCH;
                    step_nx  = '0;
                end else begin
                    step_nx = step_cnt + CW'(1);
                end
            end
            S_SWITCH: begin
                if (step_cnt == CW'(N - 1)) begin
                    state_nx = S_DONE;
                    step_nx  = '0;
                end else begin
                    step_nx = step_cnt + CW'(1);
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The last row is bypassed into the drain mux so column 0 can fire the cycle after it arrives.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            tile_nx[r] = tile[r];
            if (xfer && row_cnt == CW'(r)) begin
                tile_nx[r] = in_data;
            end
        end
    end

    always_comb begin
        int t;
        t         = int'(step_nx);
        weight_nx = '0;
        accept_nx = '0;
        switch_nx = '0;
        for (int c = 0; c < N; c++) begin
            if (state_nx == S_DRAIN && t >= c && t < c + N) begin
                accept_nx[c] = 1'b1;
                for (int r = 0; r < N; r++) begin
                    if (r == N - 1 - (t - c)) begin
                        weight_nx[c*DATA_WIDTH +: DATA_WIDTH] = tile_nx[r][c*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
        for (int r = 0; r < N; r++) begin
            if (state_nx == S_SWITCH && t == r) begin
                switch_nx[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            row_cnt         <= '0;
            step_cnt        <= '0;
            in_ready        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            wf_weight_out   <= '0;
            wf_accept_w_out <= '0;
            wf_switch_out   <= '0;
        end else begin
            state           <= state_nx;
            row_cnt         <= row_nx;
            step_cnt        <= step_nx;
            in_ready        <= (state_nx == S_IDLE) || (state_nx == S_LOAD);
            busy            <= (state_nx != S_IDLE);
            done            <= (state_nx == S_DONE);
            wf_weight_out   <= weight_nx;
            wf_accept_w_out <= accept_nx;
            wf_switch_out   <= switch_nx;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            tile[r] <= tile_nx[r];
        end
    end

endmodule

// File: tb/tb_weight_feeder.sv
// Directed bench for weight_feeder: table-driven N=2 vectors plus hand-written
// N=4 sweep and mid-drain reset sequences.
module tb_weight_feeder;

    logic        clk;
    logic        rst;

    logic [31:0] in_data2;
    logic        in_valid2;
    logic        in_ready2;
    logic [31:0] w2;
    logic [1:0]  acc2;
    logic [1:0]  sw2;
    logic        busy2;
    logic        done2;

    logic [63:0] in_data4;
    logic        in_valid4;
    logic        in_ready4;
    logic [63:0] w4;
    logic [3:0]  acc4;
    logic [3:0]  sw4;
    logic        busy4;
    logic        done4;

    int pass_count  = 0;
    int total_count = 0;

    weight_feeder #(.N(2), .DATA_WIDTH(16)) dut2 (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data2),
        .in_valid        (in_valid2),
        .in_ready        (in_ready2),
        .wf_weight_out   (w2),
        .wf_accept_w_out (acc2),
        .wf_switch_out   (sw2),
        .busy            (busy2),
        .done            (done2)
    );

    weight_feeder #(.N(4), .DATA_WIDTH(16)) dut4 (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data4),
        .in_valid        (in_valid4),
        .in_ready        (in_ready4),
        .wf_weight_out   (w4),
        .wf_accept_w_out (acc4),
        .wf_switch_out   (sw4),
        .busy            (busy4),
        .done            (done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        ready;
        logic        busy;
        logic [1:0]  acc;
        logic [31:0] w;
        logic [1:0]  sw;
        logic        done;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic rdy,
                                input logic bsy, input logic [1:0] a, input logic [31:0] w,
                                input logic [1:0] s, input logic dn);
        vec_t x;
        x.valid = v;
        x.data  = d;
        x.ready = rdy;
        x.busy  = bsy;
        x.acc   = a;
        x.w     = w;
        x.sw    = s;
        x.done  = dn;
        return x;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_dut2(input string tag, input logic rdy, input logic bsy, input logic [1:0] a,
                              input logic [31:0] w, input logic [1:0] s, input logic dn);
        check_output({tag, " in_ready"}, 64'(in_ready2), 64'(rdy));
        check_output({tag, " busy"},     64'(busy2),     64'(bsy));
        check_output({tag, " accept"},   64'(acc2),      64'(a));
        check_output({tag, " weight"},   64'(w2),        64'(w));
        check_output({tag, " switch"},   64'(sw2),       64'(s));
        check_output({tag, " done"},     64'(done2),     64'(dn));
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        in_valid2 = v.valid;
        in_data2  = v.data;
        @(posedge clk);
        #1;
        check_dut2(tag, v.ready, v.busy, v.acc, v.w, v.sw, v.done);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0]  exp_acc;
        logic [63:0] exp_w;
        logic [3:0]  exp_sw;

        rst       = 1'b1;
        in_valid2 = 1'b0;
        in_data2  = '0;
        in_valid4 = 1'b0;
        in_data4  = '0;

        // Basic tile [1,2],[3,4] then idle
        tbl.push_back(mk(1'b1, 32'h0002_0001, 1'b1, 1'b1, 2'b00, 32'h0000_0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0004_0003, 1'b0, 1'b1, 2'b01, 32'h0000_0003, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b11, 32'h0004_0001, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b10, 32'h0002_0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 2'b01, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 2'b10, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 2'b00, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 2'b00, 32'h0000_0000, 2'b00, 1'b0));
        // Signed data with backpressure, then [9,9] held through the busy phase
        tbl.push_back(mk(1'b1, 32'hFFFB_8000, 1'b1, 1'b1, 2'b00, 32'h0000_0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b1, 1'b1, 2'b00, 32'h0000_0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b1, 1'b1, 2'b00, 32'h0000_0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b1, 1'b1, 2'b00, 32'h0000_0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0007_FFFB, 1'b0, 1'b1, 2'b01, 32'h0000_FFFB, 2'b00, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0009_0009, 1'b0, 1'b1, 2'b11, 32'h0007_8000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0009_0009, 1'b0, 1'b1, 2'b10, 32'hFFFB_0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0009_0009, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 2'b01, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0009_0009, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 2'b10, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0009_0009, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 2'b00, 1'b1));
        tbl.push_back(mk(1'b1, 32'h0009_0009, 1'b1, 1'b0, 2'b00, 32'h0000_0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0009_0009, 1'b1, 1'b1, 2'b00, 32'h0000_0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0006_0005, 1'b0, 1'b1, 2'b01, 32'h0000_0005, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b11, 32'h0006_0009, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b10, 32'h0009_0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 2'b01, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 2'b10, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 2'b00, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 2'b00, 32'h0000_0000, 2'b00, 1'b0));

        #3 rst = 1'b0;
        #1;
        check_dut2("reset", 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 1'b0);
        check_output("reset n4 outputs", {w4[47:0], acc4, sw4, in_ready4, busy4, done4, 5'b0},
                     64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_dut2("post-reset", 1'b1, 1'b0, 2'b00, 32'h0, 2'b00, 1'b0);
        check_output("post-reset n4 in_ready", 64'(in_ready4), 64'h1);

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // N=4 sweep: row r lane c = r*4+c, rows back to back
        for (int r = 0; r < 4; r++) begin
            in_valid4 = 1'b1;
            for (int c = 0; c < 4; c++) in_data4[c*16 +: 16] = 16'(r * 4 + c);
            @(posedge clk);
            #1;
            if (r < 3) check_output($sformatf("n4 load%0d in_ready", r), 64'(in_ready4), 64'h1);
        end
        in_valid4 = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            exp_acc = '0;
            exp_w   = '0;
            exp_sw  = '0;
            for (int c = 0; c < 4; c++) begin
                if (k >= c + 1 && k <= c + 4) begin
                    exp_acc[c]         = 1'b1;
                    exp_w[c*16 +: 16]  = 16'(12 - 4 * (k - 1 - c) + c);
                end
            end
            if (k >= 8 && k <= 11) exp_sw[k-8] = 1'b1;
            check_output($sformatf("n4 k%0d accept", k), 64'(acc4), 64'(exp_acc));
            check_output($sformatf("n4 k%0d weight", k), w4, exp_w);
            check_output($sformatf("n4 k%0d switch", k), 64'(sw4), 64'(exp_sw));
            check_output($sformatf("n4 k%0d done", k), 64'(done4), 64'(k == 12));
            check_output($sformatf("n4 k%0d in_ready", k), 64'(in_ready4), 64'(k == 13));
            check_output($sformatf("n4 k%0d busy", k), 64'(busy4), 64'(k <= 12));
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-drain at t=1: outputs clear at once, partial tile discarded
        for (int i = 0; i < 3; i++) apply_stimulus(tbl[i], $sformatf("pre-rst vec%0d", i));
        #1 rst = 1'b0;
        #1;
        check_dut2("mid-drain reset", 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_dut2($sformatf("held reset %0d", i), 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_dut2("release", 1'b1, 1'b0, 2'b00, 32'h0, 2'b00, 1'b0);
        for (int i = 0; i < 8; i++) apply_stimulus(tbl[i], $sformatf("rerun vec%0d", i));

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
